// File: rtl/ddr_pkg.sv
// Shared types and constants for the chart playback path.
package ddr_pkg;
  localparam int LANES      = 4;
  localparam int ROM_RD_LAT = 2;

  typedef logic [LANES-1:0] lane_mask_t;
  typedef logic [3:0]       timing_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    DRAIN,
    DONE
  } seq_state_e;
endpackage

// File: rtl/arrow_field.sv
// Scroll field: DEPTH_P rows of lane masks, row 0 is the hit line; each shift moves rows one step toward row 0.
module arrow_field
  import ddr_pkg::*;
#(
  parameter int DEPTH_P = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     shift_i,
  input  lane_mask_t               row_i,
  input  logic                     clear_i,
  output logic [LANES*DEPTH_P-1:0] field_o
);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      field_o <= '0;
    end else if (clear_i) begin
      field_o <= '0;
    end else if (shift_i) begin
      field_o <= {row_i, field_o[LANES*DEPTH_P-1:LANES]};
    end
  end

endmodule

// File: rtl/chart_sequencer.sv
// Chart playback engine: fetches entries from the chart ROM, holds each for its tick count, scrolls arrows.
// Optional SEQ_PAUSE_EN adds pause_i, which freezes prescaler and field while playback is active.
//
// state | meaning
// IDLE  | waiting for start_i, prescaler held at 0
// FETCH | waiting out ROM read latency, then latching the entry
// PLAY  | holding current entry for `timing` ticks, shifting field each tick
// DRAIN | terminator seen, shifting empty rows until the field is clear
// DONE  | chart finished, start_i skips the terminator and resumes
module chart_sequencer
  import ddr_pkg::*;
#(
  parameter int TICK_DIV_P = 250000,
  parameter int DEPTH_P    = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     start_i,
  input  lane_mask_t               arrows_i,
  input  timing_t                  timing_i,
`ifdef SEQ_PAUSE_EN
  input  logic                     pause_i,
`endif
  output logic                     next_o,
  output logic [LANES*DEPTH_P-1:0] field_o,
  output lane_mask_t               target_o,
  output logic                     step_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int PRESC_W = (TICK_DIV_P > 1) ? $clog2(TICK_DIV_P) : 1;
  localparam int DRAIN_W = $clog2(DEPTH_P + 1);
  localparam int FETCH_W = $clog2(ROM_RD_LAT + 1);

  seq_state_e           state_q, state_d;
  logic [PRESC_W-1:0]   presc_q;
  logic [FETCH_W-1:0]   fetch_q;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  timing_t              remain_q, remain_d;
  lane_mask_t           arrows_q, arrows_d;
  logic                 first_q, first_d;
  logic                 running, freeze, tick;
  logic                 shift, next_raw, step_raw;
  lane_mask_t           row_in;

  assign running = (state_q == FETCH) || (state_q == PLAY) || (state_q == DRAIN);

`ifdef SEQ_PAUSE_EN
  assign freeze = pause_i & running;
`else
  assign freeze = 1'b0;
`endif

  assign tick = running && !freeze && (presc_q == PRESC_W'(TICK_DIV_P - 1));

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    arrows_d = arrows_q;
    first_d  = first_q;
    drain_d  = drain_q;
    shift    = 1'b0;
    row_in   = '0;
    next_raw = 1'b0;
    step_raw = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = FETCH;
      end
      FETCH: begin
        if (fetch_q == '0) begin
          arrows_d = arrows_i;
          if (timing_i == '0) begin
            state_d = DRAIN;
            drain_d = DRAIN_W'(DEPTH_P);
          end else begin
            state_d  = PLAY;
            remain_d = timing_i;
            first_d  = 1'b1;
          end
        end
      end
      PLAY: begin
        if (tick) begin
          shift    = 1'b1;
          step_raw = 1'b1;
          row_in   = first_q ? arrows_q : '0;
          first_d  = 1'b0;
          remain_d = remain_q - 4'd1;
          if (remain_q == 4'd1) begin
            next_raw = 1'b1;
            state_d  = FETCH;
          end
        end
      end
      DRAIN: begin
        if (tick) begin
          shift    = 1'b1;
          step_raw = 1'b1;
          drain_d  = drain_q - DRAIN_W'(1);
          if (drain_q == DRAIN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        // Address still points at the terminator, so skip past it before fetching.
        if (start_i) begin
          next_raw = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      fetch_q  <= FETCH_W'(ROM_RD_LAT - 1);
      drain_q  <= '0;
      remain_q <= '0;
      arrows_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      remain_q <= remain_d;
      arrows_q <= arrows_d;
      first_q  <= first_d;
      if (!running) begin
        presc_q <= '0;
      end else if (!freeze) begin
        presc_q <= (presc_q == PRESC_W'(TICK_DIV_P - 1)) ? '0 : presc_q + PRESC_W'(1);
      end
      // Latency countdown ignores pause so the ROM data is never missed.
      if (state_q == FETCH) fetch_q <= fetch_q - FETCH_W'(1);
      else                  fetch_q <= FETCH_W'(ROM_RD_LAT - 1);
    end
  end

  arrow_field #(
    .DEPTH_P(DEPTH_P)
  ) u_field (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .shift_i (shift),
    .row_i   (row_in),
    .clear_i (!running),
    .field_o (field_o)
  );

  assign target_o = field_o[LANES-1:0];
  assign next_o   = next_raw & reset_ni;
  assign step_o   = step_raw & reset_ni;
  assign busy_o   = running;
  assign done_o   = (state_q == DONE);

endmodule

// File: tb/tb_chart_sequencer.sv
// Directed bench for chart_sequencer with a 2-cycle-latency chart ROM model (TICK_DIV_P=4, DEPTH_P=4).
module tb_chart_sequencer;
  localparam int TD = 4;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          reset_ni = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    arrows, timing, target;
  logic          next, step, busy, done;
  logic [4*DP-1:0] field;
`ifdef SEQ_PAUSE_EN
  logic          pause = 1'b0;
`endif

  logic [7:0] rom_mem [0:127];
  logic [6:0] rom_addr;
  logic [7:0] rom_q;
  logic       rom_rst = 1'b0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rom_rst) rom_addr <= '0;
    else if (next) rom_addr <= rom_addr + 7'd1;
    rom_q <= rom_mem[rom_addr];
  end

  assign arrows = rom_q[7:4];
  assign timing = rom_q[3:0];

  chart_sequencer #(
    .TICK_DIV_P(TD),
    .DEPTH_P   (DP)
  ) dut (
    .clk_i   (clk),
    .reset_ni(reset_ni),
    .start_i (start),
    .arrows_i(arrows),
    .timing_i(timing),
`ifdef SEQ_PAUSE_EN
    .pause_i (pause),
`endif
    .next_o  (next),
    .field_o (field),
    .target_o(target),
    .step_o  (step),
    .busy_o  (busy),
    .done_o  (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rom_restart();
    rom_rst = 1'b1;
    cyc();
    cyc();
    rom_rst = 1'b0;
  endtask

  task automatic do_reset();
    reset_ni = 1'b0;
    cyc();
    reset_ni = 1'b1;
  endtask

  initial begin
    int n_next;
    int n_step;
    logic [4*DP-1:0] f_or;
    logic f_bad;

    for (int i = 0; i < 128; i++) rom_mem[i] = 8'h00;

    // reset held three cycles, start ignored
    reset_ni = 1'b0;
    start    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_outputs", {field, target, step, next, busy, done}, 32'h0);
    end
    start    = 1'b0;
    reset_ni = 1'b1;

    // first entry is the terminator
    rom_mem[0] = 8'hF0;
    rom_restart();
    start  = 1'b1;
    n_next = 0;
    n_step = 0;
    f_or   = '0;
    for (int c = 1; c <= 17; c++) begin
      cyc();
      start = 1'b0;
      n_next += int'(next);
      n_step += int'(step);
      f_or   |= field;
      if (c == 16) chk("t3_done16", {done, busy}, 2'b01);
      if (c == 17) chk("t3_done17", {done, busy}, 2'b10);
    end
    chk("t3_field_zero", f_or, 32'h0);
    chk("t3_no_next", n_next, 0);
    chk("t3_steps", n_step, 4);

    // three-entry chart from IDLE
    do_reset();
    rom_mem[0] = 8'h52;
    rom_mem[1] = 8'h81;
    rom_mem[2] = 8'h00;
    rom_mem[3] = 8'h31;
    rom_mem[4] = 8'h00;
    rom_restart();
    start  = 1'b1;
    n_next = 0;
    n_step = 0;
    for (int c = 1; c <= 29; c++) begin
      cyc();
      n_next += int'(next);
      n_step += int'(step);
      case (c)
        3:  chk("t2_nostep3", {step, next}, 2'b00);
        4:  chk("t2_tick1", {step, next}, 2'b10);
        5:  chk("t2_field5", field, 32'h5000);
        8:  chk("t2_tick2", {step, next}, 2'b11);
        9:  chk("t2_field9", field, 32'h0500);
        12: chk("t2_tick3", {step, next}, 2'b11);
        13: chk("t2_field13", field, 32'h8050);
        17: chk("t2_target17", target, 32'h5);
        25: chk("t2_target25", target, 32'h8);
        28: chk("t2_done28", {done, busy}, 2'b01);
        29: chk("t2_done29", {done, busy, field}, {2'b10, 16'h0});
        default: ;
      endcase
      // start while busy must be ignored
      start = (c >= 5 && c <= 7);
    end
    chk("t2_next_count", n_next, 2);
    chk("t2_step_count", n_step, 7);

    // resume from DONE
    start = 1'b1;
    #1;
    chk("t5_skip_next", next, 1'b1);
    n_next = 0;
    for (int c = 1; c <= 21; c++) begin
      cyc();
      start = 1'b0;
      n_next += int'(next);
      if (c == 3) chk("t5_single_next", n_next, 0);
      if (c == 1 || c == 2) chk("t5_fetch", {busy, step, next}, 3'b100);
      if (c == 4)  chk("t5_tick", {step, next}, 2'b11);
      if (c == 5)  chk("t5_field", field, 32'h3000);
      if (c == 17) chk("t5_target", target, 32'h3);
      if (c == 20) chk("t5_done20", done, 1'b0);
      if (c == 21) chk("t5_done21", done, 1'b1);
    end

    // reset in the middle of PLAY
    do_reset();
    rom_restart();
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      start = 1'b0;
    end
    cyc();
    chk("t4_precond", field, 32'h5000);
    reset_ni = 1'b0;
    #1;
    chk("t4_gated", {step, next}, 2'b00);
    cyc();
    chk("t4_cleared", {field, target, step, next, busy, done}, 32'h0);
    reset_ni = 1'b1;
    start    = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      start = 1'b0;
      if (c == 3) chk("t4_phase3", step, 1'b0);
      if (c == 4) chk("t4_phase4", step, 1'b1);
    end

`ifdef SEQ_PAUSE_EN
    // pause for ten cycles while an entry is held
    do_reset();
    rom_restart();
    start  = 1'b1;
    n_step = 0;
    f_bad  = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      cyc();
      start = 1'b0;
      if (c >= 5 && c <= 17) n_step += int'(step);
      if (c >= 5 && field !== 16'h5000) f_bad = 1'b1;
      if (c == 18) chk("t6_resume", {step, next}, 2'b11);
      pause = (c >= 5 && c <= 14);
    end
    chk("t6_no_step", n_step, 0);
    chk("t6_field_frozen", f_bad, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
